// File: rtl/tbx_mem_pkg.sv
// Shared types, defaults and helpers for the TBX simulation RAM.
package tbx_mem_pkg;

  localparam int unsigned MEM_SIZE_DEF     = 65536;
  localparam logic [31:0] MEM_MASK_DEF     = 32'(MEM_SIZE_DEF - 1);
  localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0000_FFFC;
  localparam int unsigned MAX_READ_LATENCY = 8;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  // Replace only the byte lanes whose enable is set.
  function automatic word_t be_merge(input word_t old_w, input word_t new_w, input be_t be);
    word_t res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tbx_rd_pipe.sv
// Valid+data delay line; only the valid bits are reset, data stages load on valid.
module tbx_rd_pipe
  import tbx_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk_sys,
  input  logic  rst_sys_n,
  input  logic  in_valid,
  input  word_t in_data,
  output logic  out_valid,
  output word_t out_data
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_in;
  word_t            d_q  [DEPTH];
  word_t            d_in [DEPTH];

  // Stage inputs: stage 0 from the request side, others from the previous stage.
  always_comb begin
    v_in[0] = in_valid;
    d_in[0] = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      v_in[i] = v_q[i-1];
      d_in[i] = d_q[i-1];
    end
  end

  // Valid shift register; reset flushes every in-flight read.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) v_q <= '0;
    else            v_q <= v_in;
  end

  // Data stages capture only with valid, so the last stage holds the last returned word.
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (v_in[i]) d_q[i] <= d_in[i];
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: rtl/tbx_sim_ram.sv
// Word-organised simulation RAM behind the Ibex arbiter, with backdoor load and tohost.
module tbx_sim_ram
  import tbx_mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE     = MEM_SIZE_DEF,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_wdata,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic        sim_done,
  output logic [31:0] sim_code
);

  localparam int unsigned MEM_WORDS = MEM_SIZE / 4;
  localparam int unsigned AW        = $clog2(MEM_WORDS);

  word_t          mem_q [MEM_WORDS];
  logic [AW-1:0]  bus_idx;
  logic [AW-1:0]  ld_idx;
  logic [AW-1:0]  tohost_idx;
  logic           bus_wr;
  logic           bus_rd;
  logic           tohost_hit;
  word_t          rd_word;
  logic           pipe_valid;
  word_t          pipe_data;
  logic           rd_seen_q;
  logic           unused_addr;

  assign bus_idx     = mem_addr[AW+1:2];
  assign ld_idx      = ld_addr[AW+1:2];
  assign tohost_idx  = TOHOST_ADDR[AW+1:2];
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

  assign bus_wr     = mem_req & mem_write;
  assign bus_rd     = mem_req & ~mem_write;
  assign ld_gnt     = ld_req & ~mem_req;
  assign tohost_hit = bus_wr && (bus_idx == tohost_idx) && (mem_be == 4'hF);
  assign rd_word    = mem_q[bus_idx];

  // Array update: bus writes per byte lane, backdoor loads as full words when granted.
  always_ff @(posedge clk_sys) begin
    if (bus_wr)      mem_q[bus_idx] <= be_merge(mem_q[bus_idx], mem_wdata, mem_be);
    else if (ld_gnt) mem_q[ld_idx]  <= ld_wdata;
  end

  tbx_rd_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .in_valid  (bus_rd),
    .in_data   (rd_word),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  // Remembers whether any read has returned since reset, so rdata reads zero until then.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n)      rd_seen_q <= 1'b0;
    else if (pipe_valid) rd_seen_q <= 1'b1;
  end

  assign mem_rvalid = pipe_valid;
  assign mem_rdata  = (pipe_valid | rd_seen_q) ? pipe_data : 32'h0;

  // Tohost capture: first full-word write sets done and latches the code.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sim_done <= 1'b0;
      sim_code <= 32'h0;
    end else if (tohost_hit && !sim_done) begin
      sim_done <= 1'b1;
      sim_code <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_tbx_sim_ram.sv
// Directed self-checking bench for tbx_sim_ram at READ_LATENCY 1 and 3.
module tb_tbx_sim_ram;

  logic        clk_sys;
  logic        rst_sys_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;

  logic        rvalid1, rvalid3;
  logic [31:0] rdata1, rdata3;
  logic        gnt1, gnt3;
  logic        done1, done3;
  logic [31:0] code1, code3;

  int total;
  int bad;

  tbx_sim_ram #(.READ_LATENCY(1)) u_lat1 (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(rvalid1), .mem_rdata(rdata1),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(gnt1),
    .sim_done(done1), .sim_code(code1)
  );

  tbx_sim_ram #(.READ_LATENCY(3)) u_lat3 (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(rvalid3), .mem_rdata(rdata3),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(gnt3),
    .sim_done(done3), .sim_code(code3)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic drive_idle();
    mem_req = 1'b0; mem_write = 1'b0; mem_addr = 32'h0; mem_be = 4'h0; mem_wdata = 32'h0;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_req = 1'b1; mem_write = 1'b1; mem_addr = a; mem_be = be; mem_wdata = d;
  endtask

  task automatic drive_rd(input logic [31:0] a);
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = a; mem_be = 4'h0; mem_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    drive_idle();
    ld_req = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    #12;
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL reset_rvalid1 got=%b want=0", rvalid1); end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h want=0", rdata1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got=%b want=0", done1); end
    total++; if (code1 !== 32'h0) begin bad++; $display("FAIL reset_code1 got=%h want=0", code1); end
    total++; if (rvalid3 !== 1'b0) begin bad++; $display("FAIL reset_rvalid3 got=%b want=0", rvalid3); end
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_byte_merge();
    @(negedge clk_sys); drive_wr(32'h100, 32'hA5A5A5A5, 4'hF);
    @(negedge clk_sys); drive_wr(32'h100, 32'h000000FF, 4'b0001);
    @(negedge clk_sys);
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL merge_no_rvalid_on_write got=%b want=0", rvalid1); end
    drive_rd(32'h100);
    @(negedge clk_sys);
    total++; if (rvalid1 !== 1'b1) begin bad++; $display("FAIL merge_rvalid got=%b want=1", rvalid1); end
    total++; if (rdata1 !== 32'hA5A5A5FF) begin bad++; $display("FAIL merge_rdata got=%h want=a5a5a5ff", rdata1); end
    drive_idle();
    @(negedge clk_sys);
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL merge_rvalid_pulse got=%b want=0", rvalid1); end
    total++; if (rdata1 !== 32'hA5A5A5FF) begin bad++; $display("FAIL merge_rdata_hold got=%h want=a5a5a5ff", rdata1); end
  endtask

  task automatic test_latency3();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      if (i > 0) begin
        total++; if (rvalid3 !== 1'b0) begin bad++; $display("FAIL lat3_write_rvalid i=%0d got=%b want=0", i, rvalid3); end
      end
      drive_wr(32'(4 * i), exp_d[i], 4'hF);
    end
    @(negedge clk_sys); drive_idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      total++; if (rvalid3 !== 1'b0) begin bad++; $display("FAIL lat3_idle_rvalid k=%0d got=%b want=0", k, rvalid3); end
    end
    for (int s = 0; s < 7; s++) begin
      @(negedge clk_sys);
      if (s >= 3 && s <= 5) begin
        total++; if (rvalid3 !== 1'b1) begin bad++; $display("FAIL lat3_rvalid s=%0d got=%b want=1", s, rvalid3); end
        total++; if (rdata3 !== exp_d[s-3]) begin bad++; $display("FAIL lat3_rdata s=%0d got=%h want=%h", s, rdata3, exp_d[s-3]); end
      end else begin
        total++; if (rvalid3 !== 1'b0) begin bad++; $display("FAIL lat3_rvalid_low s=%0d got=%b want=0", s, rvalid3); end
      end
      if (s < 3) drive_rd(32'(4 * s));
      else       drive_idle();
    end
  endtask

  task automatic test_backdoor();
    logic prev_req;
    @(negedge clk_sys);
    drive_idle();
    ld_req = 1'b1; ld_addr = 32'h200; ld_wdata = 32'h12345678;
    prev_req = 1'b0;
    for (int s = 0; s < 6; s++) begin
      if (s % 2 == 0) drive_rd(32'h300);
      else            drive_idle();
      #1;
      total++; if (gnt1 !== !mem_req) begin bad++; $display("FAIL ld_gnt s=%0d got=%b want=%b", s, gnt1, !mem_req); end
      total++; if (rvalid1 !== prev_req) begin bad++; $display("FAIL ld_rvalid s=%0d got=%b want=%b", s, rvalid1, prev_req); end
      prev_req = mem_req;
      @(negedge clk_sys);
    end
    ld_req = 1'b0;
    drive_rd(32'h200);
    @(negedge clk_sys);
    drive_idle();
    total++; if (rdata1 !== 32'h12345678) begin bad++; $display("FAIL ld_data got=%h want=12345678", rdata1); end
  endtask

  task automatic test_tohost();
    @(negedge clk_sys);
    drive_idle();
    ld_req = 1'b1; ld_addr = 32'hFFFC; ld_wdata = 32'h00000055;
    @(negedge clk_sys);
    ld_req = 1'b0;
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL tohost_load_done got=%b want=0", done1); end
    drive_wr(32'hFFFC, 32'h0000DEAD, 4'b0011);
    @(negedge clk_sys);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL tohost_partial_done got=%b want=0", done1); end
    drive_wr(32'hFFFC, 32'h00000001, 4'hF);
    @(negedge clk_sys);
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL tohost_done got=%b want=1", done1); end
    total++; if (code1 !== 32'h1) begin bad++; $display("FAIL tohost_code got=%h want=1", code1); end
    drive_wr(32'hFFFC, 32'h00000007, 4'hF);
    @(negedge clk_sys);
    drive_rd(32'hFFFC);
    total++; if (code1 !== 32'h1) begin bad++; $display("FAIL tohost_code_kept got=%h want=1", code1); end
    total++; if (done3 !== 1'b1) begin bad++; $display("FAIL tohost_done3 got=%b want=1", done3); end
    @(negedge clk_sys);
    drive_idle();
    total++; if (rdata1 !== 32'h7) begin bad++; $display("FAIL tohost_array got=%h want=7", rdata1); end
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL tohost_sticky got=%b want=1", done1); end
  endtask

  task automatic test_raw_alias();
    @(negedge clk_sys); drive_wr(32'h40, 32'hCAFEF00D, 4'hF);
    @(negedge clk_sys); drive_rd(32'h40);
    @(negedge clk_sys);
    total++; if (rdata1 !== 32'hCAFEF00D || rvalid1 !== 1'b1) begin bad++; $display("FAIL raw_data got=%h/%b want=cafef00d/1", rdata1, rvalid1); end
    drive_wr(32'h10040, 32'h0BADBEEF, 4'hF);
    @(negedge clk_sys); drive_rd(32'h40);
    @(negedge clk_sys);
    total++; if (rdata1 !== 32'h0BADBEEF) begin bad++; $display("FAIL alias_data got=%h want=0badbeef", rdata1); end
    drive_rd(32'h10040);
    @(negedge clk_sys);
    drive_idle();
    total++; if (rdata1 !== 32'h0BADBEEF) begin bad++; $display("FAIL alias_read_hi got=%h want=0badbeef", rdata1); end
  endtask

  task automatic test_reset_flush();
    @(negedge clk_sys); drive_rd(32'h0);
    @(negedge clk_sys); drive_idle();
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      total++; if (rvalid3 !== 1'b0) begin bad++; $display("FAIL flush_rvalid3 k=%0d got=%b want=0", k, rvalid3); end
    end
    total++; if (rdata3 !== 32'h0) begin bad++; $display("FAIL flush_rdata3 got=%h want=0", rdata3); end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL flush_rdata1 got=%h want=0", rdata1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL flush_done1 got=%b want=0", done1); end
    total++; if (code1 !== 32'h0) begin bad++; $display("FAIL flush_code1 got=%h want=0", code1); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_byte_merge();
    test_latency3();
    test_backdoor();
    test_tohost();
    test_raw_alias();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tbx_sim_ram.md
Name: tbx_sim_ram

Overview:
- Word-organised simulation RAM directly downstream of the Ibex instruction/data arbiter in the TBX BFM.
- Consumes the arbiter's single mem_* request channel and returns mem_rvalid/mem_rdata after a configurable read latency.
- Provides a host backdoor load port for program preload.
- Provides a tohost termination word that ends the simulation run.

Parameters:
- MEM_SIZE, 65536: bytes; power of two; at least 8.
- READ_LATENCY, 1: cycles from accepted read to mem_rvalid; legal range 1..8.
- TOHOST_ADDR, 32'h0000FFFC: word address whose write terminates the run; must fall inside the RAM.

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  asynchronous active-low reset
- mem_req  in  1  request valid; never back-pressured
- mem_addr  in  32  byte address; only bits [log2(MEM_SIZE)-1:2] are used
- mem_write  in  1  1 = write, 0 = read
- mem_be  in  4  byte enables for writes; ignored on reads
- mem_wdata  in  32  write data
- mem_rvalid  out  1  read data valid, one pulse per accepted read
- mem_rdata  out  32  read data
- ld_req  in  1  backdoor load request (full-word write)
- ld_addr  in  32  backdoor byte address; word-aligned
- ld_wdata  in  32  backdoor data
- ld_gnt  out  1  load accepted this cycle
- sim_done  out  1  sticky: tohost written
- sim_code  out  32  data of the first tohost write

Behaviour:
- Clock and reset: clk_sys; rst_sys_n asynchronous, active-low.
- Reset values: mem_rvalid=0, mem_rdata=0, sim_done=0, sim_code=0.
- Array contents are not reset.
- Reset asserted mid-operation flushes all in-flight reads: no rvalid appears after reset release for a pre-reset request.
- Word index = mem_addr[AW+1:2], where AW = log2(MEM_SIZE/4). Upper address bits are ignored; the upstream arbiter already filters range.
- One request is accepted every cycle mem_req=1. There are no stalls and no ready signal.
- Write, mem_req & mem_write:
  - Array updates at the clock edge, per byte lane where mem_be[i]=1.
  - mem_rvalid is NOT produced for writes, because instr_rvalid is tied to mem_rvalid upstream.
- Read, mem_req & !mem_write:
  - Array word is sampled at the accepting edge.
  - The word enters a READ_LATENCY-deep valid/data delay line.
  - mem_rvalid=1 with the word exactly READ_LATENCY cycles after the request cycle. With READ_LATENCY=1, rvalid is high in the cycle after the request.
  - Back-to-back reads give back-to-back rvalid pulses, in order.
- mem_rdata holds its last value when mem_rvalid=0. It does not return to zero.
- Read-after-write, same word, consecutive cycles: the read returns the new data. The write edge precedes the read sample.
- Backdoor load:
  - ld_gnt = ld_req & !mem_req, combinational. The bus always wins.
  - When ld_gnt=1, the full word is written at the edge, with all byte enables.
  - Loads never produce rvalid and never trigger tohost.
  - Host retries until ld_gnt is seen.
- Tohost:
  - Condition: a bus write with word index equal to TOHOST_ADDR's index and mem_be=4'hF.
  - On the first occurrence, sim_done goes to 1 and sim_code takes mem_wdata, both registered on the same edge.
  - Later tohost writes update the array but not sim_code.
  - A partial-byte tohost write updates the array only.
  - sim_done stays high until reset.
- Width rules:
  - Writes never alter bytes whose enables are 0.
  - No arithmetic beyond index extraction.
  - The delay-line depth counter, if used, must not wrap-alias for READ_LATENCY=8.

Decomposition:
- Package tbx_mem_pkg holds:
  - MEM_SIZE_DEF, MEM_MASK_DEF, TOHOST_ADDR_DEF, MAX_READ_LATENCY=8.
  - typedef word_t (logic [31:0]).
  - typedef be_t (logic [3:0]).
  - function be_merge(old, new, be) returning word_t.
- One sub-module, tbx_rd_pipe: a parameterised valid+data shift register of depth READ_LATENCY with asynchronous reset on the valid bits only.

Test Plan:
- Write 0xA5A5A5A5 be=F to 0x100, then write 0x0000_00FF be=4'b0001 to 0x100, then read 0x100 -> rdata 0xA5A5A5FF with rvalid exactly 1 cycle later (READ_LATENCY=1).
- READ_LATENCY=3: reads of 0x0, 0x4, 0x8 on consecutive cycles -> rvalid high on cycles 3, 4, 5 with data in order; no rvalid on any write cycle.
- ld_req held while mem_req pulses on alternate cycles -> ld_gnt only in mem_req=0 cycles; array word at ld_addr is 0x12345678 after the first grant.
- Bus write 0x00000001 be=F to 0xFFFC, then 0x00000007 -> sim_done=1 one edge after the first write, sim_code=0x00000001 retained; a prior be=4'b0011 write left sim_done=0.
- Read issued, then rst_sys_n pulsed low before the latency expires -> no rvalid after release; sim_done=0, mem_rdata=0.
- Read-after-write to 0x40 on consecutive cycles -> new data returned; 0x10040 aliases to 0x40 (MEM_SIZE=64 kB).
